// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with shift-frame counter (optional rotate: SHIFT_ROTATE_EN)
module univ_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic                     ser_in_r,
    input  logic                     ser_in_l,
    input  logic [WIDTH-1:0]         d,
`ifdef SHIFT_ROTATE_EN
    input  logic                     rot,
`endif
    output logic [WIDTH-1:0]         q,
    output logic                     ser_out_r,
    output logic                     ser_out_l,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic          fill_r;
    logic          fill_l;
    logic          cnt_wrap;
    logic [CW-1:0] cnt_step;

    // Bits entering each end on a shift: serial inputs, or the opposite end when rotating
    always_comb begin
        fill_r = ser_in_r;
        fill_l = ser_in_l;
`ifdef SHIFT_ROTATE_EN
        if (rot) begin
            fill_r = q[0];
            fill_l = q[WIDTH-1];
        end
`endif
    end

    // Next shift count; explicit compare so non-power-of-two widths wrap at WIDTH
    always_comb begin
        cnt_wrap = (cnt == CNT_LAST);
        cnt_step = cnt_wrap ? '0 : cnt + CW'(1);
    end

    // Register, counter and frame pulse; done defaults low so it lasts one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                case (mode)
                    MODE_RIGHT: begin
                        q    <= {fill_r, q[WIDTH-1:1]};
                        cnt  <= cnt_step;
                        done <= cnt_wrap;
                    end
                    MODE_LEFT: begin
                        q    <= {q[WIDTH-2:0], fill_l};
                        cnt  <= cnt_step;
                        done <= cnt_wrap;
                    end
                    MODE_LOAD: begin
                        q   <= d;
                        cnt <= '0;
                    end
                    MODE_HOLD: begin
                        q   <= q;
                        cnt <= cnt;
                    end
                    default: begin
                        q   <= q;
                        cnt <= cnt;
                    end
                endcase
            end
        end
    end

    assign ser_out_r = q[0];
    assign ser_out_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard testbench for univ_shift_reg (WIDTH=16)
module tb_univ_shift_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        ser_in_r = 1'b0;
    logic        ser_in_l = 1'b0;
    logic [15:0] d = 16'h0000;
    logic        rot = 1'b0;
    logic [15:0] q;
    logic        ser_out_r;
    logic        ser_out_l;
    logic [3:0]  cnt;
    logic        done;

    int n_tests = 0;
    int n_fail = 0;

    logic [21:0] exp_q[$];
    string       name_q[$];

    univ_shift_reg #(.WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .mode(mode),
        .ser_in_r(ser_in_r),
        .ser_in_l(ser_in_l),
        .d(d),
`ifdef SHIFT_ROTATE_EN
        .rot(rot),
`endif
        .q(q),
        .ser_out_r(ser_out_r),
        .ser_out_l(ser_out_l),
        .cnt(cnt),
        .done(done)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, return just after the rising edge
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic sr, input logic sl, input logic [15:0] dd,
                        input logic rt);
        @(negedge clk);
        rst = r; en = e; mode = m; ser_in_r = sr; ser_in_l = sl; d = dd; rot = rt;
        @(posedge clk);
        #1;
    endtask

    // Push the expected state after the edge just taken
    task automatic expect_state(input string nm, input logic [15:0] eq,
                                input logic [3:0] ec, input logic ed);
        exp_q.push_back({eq, ec, ed, eq[15]});
        name_q.push_back(nm);
    endtask

    // Monitor: compare every pending expectation against the DUT outputs
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [21:0] e;
            logic [21:0] a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {q, cnt, done, ser_out_l};
            n_tests++;
            if (a !== e || ser_out_r !== e[6]) begin
                n_fail++;
                $display("FAIL %s: q=%h cnt=%0d done=%b sol=%b sor=%b, want q=%h cnt=%0d done=%b sol=%b sor=%b",
                         nm, a[21:6], a[5:2], a[1], a[0], ser_out_r,
                         e[21:6], e[5:2], e[1], e[0], e[6]);
            end
        end
    end

    initial begin
        logic [15:0] eq;
        // Reset dominance over load
        step(1, 1, 2'b11, 0, 0, 16'hFFFF, 0);
        expect_state("reset", 16'h0000, 4'd0, 1'b0);

        // Right shift
        step(0, 1, 2'b11, 0, 0, 16'hA5C3, 0);
        expect_state("load_a5c3", 16'hA5C3, 4'd0, 1'b0);
        step(0, 1, 2'b01, 1, 0, 16'h0000, 0);
        expect_state("sr1", 16'hD2E1, 4'd1, 1'b0);
        step(0, 1, 2'b01, 1, 0, 16'h0000, 0);
        expect_state("sr2", 16'hE970, 4'd2, 1'b0);
        step(0, 1, 2'b01, 1, 0, 16'h0000, 0);
        expect_state("sr3", 16'hF4B8, 4'd3, 1'b0);
        step(0, 1, 2'b01, 1, 0, 16'h0000, 0);
        expect_state("sr4", 16'hFA5C, 4'd4, 1'b0);
        step(0, 0, 2'b01, 0, 0, 16'h0000, 0);
        expect_state("en0_hold", 16'hFA5C, 4'd4, 1'b0);
        step(0, 1, 2'b00, 0, 1, 16'h0000, 0);
        expect_state("mode00_hold", 16'hFA5C, 4'd4, 1'b0);

        // Left shift
        step(0, 1, 2'b11, 0, 0, 16'h8001, 0);
        expect_state("load_8001", 16'h8001, 4'd0, 1'b0);
        step(0, 1, 2'b10, 1, 0, 16'h0000, 0);
        expect_state("sl1", 16'h0002, 4'd1, 1'b0);

        // Two back-to-back frames: one pulse each
        step(0, 1, 2'b11, 0, 0, 16'hFFFF, 0);
        expect_state("load_ffff", 16'hFFFF, 4'd0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step(0, 1, 2'b01, 0, 1, 16'h0000, 0);
            eq = 16'hFFFF >> k;
            expect_state($sformatf("frame1_%0d", k), eq, 4'(k % 16), k == 16);
        end
        for (int j = 1; j <= 16; j++) begin
            step(0, 1, 2'b01, 1, 0, 16'h0000, 0);
            eq = 16'hFFFF << (16 - j);
            expect_state($sformatf("frame2_%0d", j), eq, 4'(j % 16), j == 16);
        end
        step(0, 0, 2'b01, 1, 0, 16'h0000, 0);
        expect_state("done_clr_en0", 16'hFFFF, 4'd0, 1'b0);

        // Frame boundary with en=0 stall, mixing directions
        step(0, 1, 2'b11, 0, 0, 16'h0000, 0);
        for (int k = 1; k <= 15; k++) step(0, 1, (k % 2 == 1) ? 2'b01 : 2'b10, 0, 0, 16'h0000, 0);
        expect_state("mixed15", 16'h0000, 4'd15, 1'b0);
        step(0, 0, 2'b01, 0, 0, 16'h0000, 0);
        step(0, 0, 2'b10, 0, 0, 16'h0000, 0);
        expect_state("stall15", 16'h0000, 4'd15, 1'b0);
        step(0, 1, 2'b10, 0, 1, 16'h0000, 0);
        expect_state("resume16", 16'h0001, 4'd0, 1'b1);

        // Reset mid-frame, then a full frame afterwards
        step(0, 1, 2'b11, 0, 0, 16'h0000, 0);
        for (int k = 1; k <= 7; k++) step(0, 1, 2'b01, 0, 0, 16'h0000, 0);
        expect_state("pre_rst7", 16'h0000, 4'd7, 1'b0);
        step(1, 1, 2'b01, 0, 0, 16'h0000, 0);
        expect_state("rst_mid", 16'h0000, 4'd0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step(0, 1, 2'b01, 0, 0, 16'h0000, 0);
            expect_state($sformatf("post_rst_%0d", k), 16'h0000, 4'(k % 16), k == 16);
        end
        step(1, 0, 2'b00, 0, 0, 16'h0000, 0);
        expect_state("rst_drops_done", 16'h0000, 4'd0, 1'b0);

        // Load at cnt=15 wins over frame completion
        step(0, 1, 2'b11, 0, 0, 16'h0000, 0);
        for (int k = 1; k <= 15; k++) step(0, 1, 2'b01, 0, 0, 16'h0000, 0);
        expect_state("cnt15", 16'h0000, 4'd15, 1'b0);
        step(0, 1, 2'b11, 0, 0, 16'h1234, 0);
        expect_state("load_at15", 16'h1234, 4'd0, 1'b0);
        step(0, 1, 2'b00, 0, 0, 16'h0000, 0);
        expect_state("after_load15", 16'h1234, 4'd0, 1'b0);

        // Rotate
        step(0, 1, 2'b11, 0, 0, 16'h0001, 0);
        step(0, 1, 2'b01, 0, 0, 16'h0000, 1);
`ifdef SHIFT_ROTATE_EN
        expect_state("rot_right", 16'h8000, 4'd1, 1'b0);
        step(0, 1, 2'b10, 0, 0, 16'h0000, 1);
        expect_state("rot_left", 16'h0001, 4'd2, 1'b0);
`else
        expect_state("norot_right", 16'h0000, 4'd1, 1'b0);
        step(0, 1, 2'b10, 0, 1, 16'h0000, 1);
        expect_state("norot_left", 16'h0001, 4'd2, 1'b0);
`endif

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register with a shift-frame counter. It holds a WIDTH-bit word and, under a clock enable, can hold it, shift it right, shift it left or parallel-load it. It counts shifts since the last load and pulses `done` when a full WIDTH-bit frame has been shifted. It replaces the fixed 16-bit right-only shifter in the serial/LED datapaths, and is a bit-exact superset of it in shift-right mode.

## Interface
- `WIDTH`, default 16: register width; legal values are WIDTH ≥ 2.
- `CW` (localparam), value `$clog2(WIDTH)`: counter width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  step enable; when 0, all state holds.
- `mode`  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `ser_in_r`  in  1  bit entering at the MSB on a right shift.
- `ser_in_l`  in  1  bit entering at the LSB on a left shift.
- `d`  in  WIDTH  parallel load data.
- `rot`  in  1  rotate select; this port exists only with `SHIFT_ROTATE_EN`.
- `q`  out  WIDTH  register contents.
- `ser_out_r`  out  1  `q[0]` (combinational from `q`).
- `ser_out_l`  out  1  `q[WIDTH-1]` (combinational from `q`).
- `cnt`  out  CW  shifts performed since the last load or reset.
- `done`  out  1  one-cycle frame-complete pulse.

## Operation
- Reset values: `q` = 0, `cnt` = 0, `done` = 0.
- Priority at each edge: `rst` > `en`=0 (hold) > `mode`.
- Mode 01 (shift right): `q` ← {`ser_in_r`, `q[WIDTH-1:1]`}.
- Mode 10 (shift left): `q` ← {`q[WIDTH-2:0]`, `ser_in_l`}.
- Mode 11 (parallel load): `q` ← `d`; `cnt` ← 0; `done` ← 0.
- Mode 00: `q` holds and `cnt` holds, even when `en`=1.
- Counter:
  - Every shift (mode 01 or 10 with `en`=1) increments `cnt`.
  - When a shift occurs with `cnt` = WIDTH-1, `cnt` wraps to 0 and `done` is set.
  - Left and right shifts share one counter; direction changes do not clear it.
- `done` is registered:
  - High for exactly the one cycle after the edge that performed the WIDTH-th shift.
  - Cleared at the next edge regardless of inputs, including `en`=0.
  - Back-to-back frames produce one pulse every WIDTH shifts.
- Arithmetic: `cnt` is unsigned modulo WIDTH.
  - For a non-power-of-two WIDTH, the wrap is an explicit compare, not natural overflow.
- Legacy equivalence: with WIDTH=16, mode=01, `ser_in_r`=step and `en`=ld, `q` is bit-identical to the old 16-bit shifter.

## Timing
- Single clock domain; no combinational path from inputs to `q`, `cnt` or `done`.
- Latency: a `q` change is visible one cycle after the enabling edge.
- `ser_out_r` and `ser_out_l` follow `q` in the same cycle, so the bit shifted out is presented before the edge that removes it.
- Reset mid-frame: `cnt` is cleared and no `done` pulse follows, even if the frame would have completed.
- Reset asserted while `done` is high: `done` drops at that edge.
- Load in the same cycle that `cnt` = WIDTH-1: the load wins; `cnt` = 0 and no `done`.
- `en`=0 across a frame boundary: the count freezes and resumes exactly where it stopped.

## Configuration
- Macro: `SHIFT_ROTATE_EN`.
- Defined:
  - The `rot` input exists.
  - When `rot`=1, the right shift feeds `q[0]` into the MSB and the left shift feeds `q[WIDTH-1]` into the LSB; the `ser_in_*` inputs are ignored.
  - Counting and `done` behave exactly as for a normal shift.
- Undefined:
  - No `rot` port and no rotate logic.
  - Shifts always take `ser_in_r` / `ser_in_l`.

## Test plan
All scenarios use WIDTH=16.
- Reset dominance: `rst`=1, `en`=1, `mode`=11, `d`=16'hFFFF -> after the edge, `q`=16'h0000, `cnt`=0, `done`=0.
- Right shift: load 16'hA5C3, then 4 right shifts with `ser_in_r`=1 -> `q`=16'hFA5C, `cnt`=4. A following `en`=0 cycle leaves `q` and `cnt` unchanged.
- Left shift: load 16'h8001 -> `ser_out_l`=1. One left shift with `ser_in_l`=0 -> `q`=16'h0002, `ser_out_l`=0, `cnt`=1.
- Frame pulse: load, then 16 consecutive right shifts -> `done`=1 for exactly one cycle after the 16th edge, `cnt`=0. A further 16 shifts -> exactly one more pulse.
- Reset and load boundaries:
  - 7 shifts, then `rst` -> `cnt`=0; then 16 more shifts -> the pulse comes only after the 16th of them.
  - Load coinciding with `cnt`=15 -> no `done`.
- Rotate:
  - With the macro defined: load 16'h0001, `rot`=1, one right shift -> `q`=16'h8000.
  - Without the macro: the same sequence with `ser_in_r`=0 -> `q`=16'h0000.
